// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and the round-constant lookup
// used by the key-expansion controller.
`default_nettype none

package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] r;
    case (rc)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_expand_ctrl_round_key_gen.sv
// One combinational AES-128 key-schedule round: next round key from the
// current round key and the round counter.
`default_nettype none

module round_key_generator
  import aes_pkg::*;
(
  input  logic [3:0]       rc,
  input  logic [KEY_W-1:0] inkey,
  output logic [KEY_W-1:0] outkey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = inkey[127:96];
  assign w1  = inkey[95:64];
  assign w2  = inkey[63:32];
  assign w3  = inkey[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    sbox u_sbox (
      .din  (rot[8*i +: 8]),
      .dout (sub[8*i +: 8])
    );
  end

  assign n0 = w0 ^ sub ^ {rcon(rc), 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign outkey = {n0, n1, n2, n3};

endmodule

`default_nettype wire

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) multiplicative inverse (x^254) followed by the
// FIPS-197 affine transform.
`default_nettype none

module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Addition chain for x^254; zero maps to zero as the S-box requires.
  assign x2   = gf_mul(din, din);
  assign x3   = gf_mul(x2, din);
  assign x6   = gf_mul(x3, x3);
  assign x7   = gf_mul(x6, din);
  assign x14  = gf_mul(x7, x7);
  assign x15  = gf_mul(x14, din);
  assign x30  = gf_mul(x15, x15);
  assign x31  = gf_mul(x30, din);
  assign x62  = gf_mul(x31, x31);
  assign x63  = gf_mul(x62, din);
  assign x126 = gf_mul(x63, x63);
  assign x127 = gf_mul(x126, din);
  assign inv  = gf_mul(x127, x127);

  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/aes_key_expand_ctrl.sv
// Sequential AES-128 key expansion: one round per clock into an 11-entry
// round-key register file with a registered read port.
`default_nettype none

module aes_key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rd_addr,
  output logic [KEY_W-1:0] rd_key
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_key_expand_ctrl: only NR = 10 (AES-128) is supported");
  end

  state_t           state;
  logic [3:0]       rc;
  logic [KEY_W-1:0] cur;
  logic [KEY_W-1:0] next_key;
  logic [KEY_W-1:0] store [0:AES_NR];
  logic             accept;

  // key_ready is registered and high only in IDLE/DONE, so it gates acceptance.
  assign accept = key_valid & key_ready;

  round_key_generator u_rkg (
    .rc     (rc),
    .inkey  (cur),
    .outkey (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rc         <= 4'd0;
      cur        <= '0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state      <= EXPAND;
            cur        <= key_in;
            rc         <= 4'd0;
            keys_valid <= 1'b0;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        EXPAND: begin
          cur <= next_key;
          if (rc == 4'd9) begin
            state      <= DONE;
            rc         <= 4'd0;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= AES_NR; i++) store[i] <= '0;
    end else if (accept) begin
      store[0] <= key_in;
    end else if (state == EXPAND) begin
      store[rc + 4'd1] <= next_key;
    end
  end

  // Reads see pre-edge contents, so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key <= '0;
    end else if (rd_addr <= 4'd10) begin
      rd_key <= store[rd_addr];
    end else begin
      rd_key <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_ctrl.sv
// Self-checking bench for aes_key_expand_ctrl: FIPS-197 word-level schedule
// model with cycle-level reference, plus literal known-answer checks.
`default_nettype none

module tb_aes_key_expand_ctrl;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RA  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KOTH  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready, busy, done, keys_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int tests = 0;
  int fails = 0;

  aes_key_expand_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Textbook word recurrence w[i] = w[i-4] ^ temp, Rcon by repeated doubling.
  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcv;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcv, 24'h000000};
        rcv = {rcv[6:0], 1'b0} ^ (rcv[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level reference built from the externally visible timing rules.
  logic [127:0] m_store [11];
  logic [127:0] m_key, m_rd;
  logic         m_ready, m_busy, m_done, m_kv;
  int           m_round;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) m_store[i] <= '0;
      m_key <= '0; m_rd <= '0; m_ready <= 1'b1; m_busy <= 1'b0;
      m_done <= 1'b0; m_kv <= 1'b0; m_round <= 0;
    end else begin
      m_rd   <= (rd_addr < 4'd11) ? m_store[rd_addr] : '0;
      m_done <= 1'b0;
      if (m_busy) begin
        m_store[m_round] <= round_key(m_key, m_round);
        m_round <= m_round + 1;
        if (m_round == 10) begin
          m_busy <= 1'b0; m_ready <= 1'b1; m_done <= 1'b1; m_kv <= 1'b1;
        end
      end else if (key_valid && m_ready) begin
        m_key <= key_in; m_store[0] <= key_in; m_round <= 1;
        m_busy <= 1'b1; m_ready <= 1'b0; m_kv <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("key_ready", 128'(key_ready), 128'(m_ready));
    check("busy", 128'(busy), 128'(m_busy));
    check("done", 128'(done), 128'(m_done));
    check("keys_valid", 128'(keys_valid), 128'(m_kv));
    check("rd_key", rd_key, m_rd);
  end

  task automatic load(input logic [127:0] k);
    @(posedge clk); #2;
    key_in = k; key_valid = 1'b1;
    @(posedge clk); #2;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input bit hold, input logic [127:0] other, output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (hold && n < 10) begin
        key_valid = 1'b1; key_in = other;
      end else begin
        key_valid = 1'b0;
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [127:0] exp, input string name);
    @(posedge clk); #2;
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    check(name, rd_key, exp);
  endtask

  initial begin
    int n;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    key_in = '0; key_valid = 1'b0; rd_addr = 4'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset key_ready", 128'(key_ready), 128'd1);
    check("reset busy", 128'(busy), 128'd0);
    check("reset keys_valid", 128'(keys_valid), 128'd0);
    check("reset rd_key", rd_key, 128'd0);

    check("model K1 r1", round_key(K1, 1), K1_R1);
    check("model K1 r10", round_key(K1, 10), K1_RA);
    check("model zero r1", round_key(128'd0, 1), Z_R1);
    check("model zero r10", round_key(128'd0, 10), Z_RA);

    @(posedge clk); #2 rst_n = 1'b1;

    // K1 with key_valid held during EXPAND carrying a different key
    load(K1);
    wait_done(1'b1, KOTH, n);
    check("K1 done latency", 128'(n), 128'd11);
    rd_check(4'd0, K1, "K1 rd0");
    rd_check(4'd1, K1_R1, "K1 rd1");
    rd_check(4'd10, K1_RA, "K1 rd10");

    for (int a = 0; a < 16; a++)
      rd_check(4'(a), (a < 11) ? round_key(K1, a) : 128'd0, "sweep");

    // back-to-back: zero key loaded in the done cycle
    load(K1);
    wait_done(1'b0, '0, n);
    check("b2b first latency", 128'(n), 128'd11);
    key_in = '0; key_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b keys_valid drop", 128'(keys_valid), 128'd0);
    check("b2b busy", 128'(busy), 128'd1);
    key_valid = 1'b0;
    wait_done(1'b0, '0, n);
    check("b2b second latency", 128'(n), 128'd11);
    rd_check(4'd1, Z_R1, "zero rd1");
    rd_check(4'd10, Z_RA, "zero rd10");

    // reset in the middle of EXPAND
    load(K1);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset busy", 128'(busy), 128'd0);
    check("midreset keys_valid", 128'(keys_valid), 128'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset key_ready", 128'(key_ready), 128'd1);
    rd_check(4'd0, 128'd0, "post-reset rd0");
    rd_check(4'd10, 128'd0, "post-reset rd10");
    load(128'd0);
    wait_done(1'b0, '0, n);
    check("post-reset latency", 128'(n), 128'd11);
    rd_check(4'd10, Z_RA, "post-reset zero rd10");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
